// File: rtl/wb_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter_pkg
// Purpose  : Shared constants and types for the writeback port arbiter:
//            mux select encodings, priority pointer encoding, default widths.
// Revision : 1.0  initial release
// ============================================================================
package wb_port_arbiter_pkg;

   // Default widths for the register-file write port
   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;

   // Destination-register mux select values (1 passes requester A)
   localparam logic SEL_A = 1'b1;
   localparam logic SEL_B = 1'b0;

   // Round-robin priority pointer: names the side that wins a tie
   typedef enum logic {
      PRI_B = 1'b0,
      PRI_A = 1'b1
   } pri_e;

endpackage : wb_port_arbiter_pkg
`default_nettype wire

// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter_if
// Purpose  : Bundle of the two writeback request channels and the
//            register-file write port. The slave side is the arbiter; the
//            master side is the requesters together with the register file.
// Revision : 1.0  initial release
// ============================================================================
interface wb_port_arbiter_if #(
   parameter int DATA_W = wb_port_arbiter_pkg::DEF_DATA_W,
   parameter int ADDR_W = wb_port_arbiter_pkg::DEF_ADDR_W
) ();

   // Requester A (ALU / primary path)
   logic              ReqA;
   logic [ADDR_W-1:0] AddrA;
   logic [DATA_W-1:0] DataA;
   logic              AckA;

   // Requester B (load / secondary path)
   logic              ReqB;
   logic [ADDR_W-1:0] AddrB;
   logic [DATA_W-1:0] DataB;
   logic              AckB;

   // Register-file write port and status
   logic              MuxSel;
   logic              WrEn;
   logic [ADDR_W-1:0] WrAddr;
   logic [DATA_W-1:0] WrData;
   logic              Busy;

   modport slave (
      input  ReqA, AddrA, DataA,
      input  ReqB, AddrB, DataB,
      output AckA, AckB, MuxSel, WrEn, WrAddr, WrData, Busy
   );

   modport master (
      output ReqA, AddrA, DataA,
      output ReqB, AddrB, DataB,
      input  AckA, AckB, MuxSel, WrEn, WrAddr, WrData, Busy
   );

endinterface : wb_port_arbiter_if
`default_nettype wire

// File: rtl/wb_port_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter_rr_arbiter2
// Purpose  : Two-way round-robin arbiter (rr_arbiter2). A request raised in
//            the same cycle as its own acknowledge is treated as already
//            consumed. The pointer flips to the other side after each grant
//            and holds when nothing is granted.
// Revision : 1.0  initial release
// ============================================================================
module wb_port_arbiter_rr_arbiter2 (
   input  logic Clk,
   input  logic Rst,
   input  logic req_a,
   input  logic req_b,
   input  logic ack_a,
   input  logic ack_b,
   output logic grant_a,
   output logic grant_b
);
   import wb_port_arbiter_pkg::*;

   pri_e pri_q;
   pri_e pri_d;
   logic elig_a;
   logic elig_b;

   assign elig_a = req_a & ~ack_a;
   assign elig_b = req_b & ~ack_b;

   // Grant: a lone eligible side wins, a tie goes to the side the pointer names
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (elig_a && elig_b) begin
         grant_a = (pri_q == PRI_A);
         grant_b = (pri_q == PRI_B);
      end else begin
         grant_a = elig_a;
         grant_b = elig_b;
      end
   end

   // Pointer next state: hand priority to the side that just lost out
   always_comb begin
      pri_d = pri_q;
      if (grant_a) begin
         pri_d = PRI_B;
      end else if (grant_b) begin
         pri_d = PRI_A;
      end
   end

   // Pointer register, A favoured out of reset
   always_ff @(posedge Clk) begin
      if (Rst) begin
         pri_q <= PRI_A;
      end else begin
         pri_q <= pri_d;
      end
   end

endmodule : wb_port_arbiter_rr_arbiter2
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Shares the register-file write port between the ALU (A) and
//            load (B) writeback paths. Grants round-robin, then presents a
//            registered write address/data/enable one cycle later together
//            with a one-cycle acknowledge. Writes to register $0 are
//            acknowledged but never enabled.
// Revision : 1.0  initial release
// ============================================================================
module wb_port_arbiter #(
   parameter int DATA_W = wb_port_arbiter_pkg::DEF_DATA_W,
   parameter int ADDR_W = wb_port_arbiter_pkg::DEF_ADDR_W
) (
   input  logic              Clk,
   input  logic              Rst,
   wb_port_arbiter_if.slave  bus
);
   import wb_port_arbiter_pkg::*;

   logic              grant_a;
   logic              grant_b;

   logic              ack_a_q,   ack_a_d;
   logic              ack_b_q,   ack_b_d;
   logic              mux_sel_q, mux_sel_d;
   logic              wr_en_q,   wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;

   wb_port_arbiter_rr_arbiter2 u_rr (
      .Clk     (Clk),
      .Rst     (Rst),
      .req_a   (bus.ReqA),
      .req_b   (bus.ReqB),
      .ack_a   (ack_a_q),
      .ack_b   (ack_b_q),
      .grant_a (grant_a),
      .grant_b (grant_b)
   );

   // Next output values: load the granted side, otherwise hold select/addr/data
   always_comb begin
      ack_a_d   = grant_a;
      ack_b_d   = grant_b;
      mux_sel_d = mux_sel_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      wr_en_d   = 1'b0;
      if (grant_a) begin
         mux_sel_d = SEL_A;
         wr_addr_d = bus.AddrA;
         wr_data_d = bus.DataA;
         wr_en_d   = (bus.AddrA != '0);
      end else if (grant_b) begin
         mux_sel_d = SEL_B;
         wr_addr_d = bus.AddrB;
         wr_data_d = bus.DataB;
         wr_en_d   = (bus.AddrB != '0);
      end
   end

   // Output registers; reset discards any request pending at the same edge
   always_ff @(posedge Clk) begin
      if (Rst) begin
         ack_a_q   <= 1'b0;
         ack_b_q   <= 1'b0;
         mux_sel_q <= SEL_A;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         ack_a_q   <= ack_a_d;
         ack_b_q   <= ack_b_d;
         mux_sel_q <= mux_sel_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign bus.AckA   = ack_a_q;
   assign bus.AckB   = ack_b_q;
   assign bus.MuxSel = mux_sel_q;
   assign bus.WrEn   = wr_en_q;
   assign bus.WrAddr = wr_addr_q;
   assign bus.WrData = wr_data_q;
   assign bus.Busy   = (bus.ReqA & ~ack_a_q) | (bus.ReqB & ~ack_b_q);

endmodule : wb_port_arbiter
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arbiter
// Purpose  : Self-checking bench for wb_port_arbiter: directed scenarios
//            followed by randomized traffic against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_port_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;

   logic Clk = 1'b0;
   logic Rst;

   always #5 Clk = ~Clk;

   wb_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   int total  = 0;
   int passed = 0;

   // Behavioural model state: what the outputs should show after each edge
   bit          m_ack_a, m_ack_b, m_sel, m_en;
   bit          m_next_is_a;   // which side wins the next tie
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;

   int wr_cnt;
   bit seen_b, bad_addr;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Advance one clock: predict from the current inputs, then compare outputs
   task automatic step();
      int winner;   // 0 none, 1 A, 2 B
      bit want_a, want_b;
      if (Rst) begin
         m_ack_a = 0; m_ack_b = 0; m_en = 0; m_sel = 1;
         m_addr = '0; m_data = '0; m_next_is_a = 1;
      end else begin
         want_a = bus.ReqA && !m_ack_a;
         want_b = bus.ReqB && !m_ack_b;
         if (want_a && want_b) winner = m_next_is_a ? 1 : 2;
         else if (want_a)      winner = 1;
         else if (want_b)      winner = 2;
         else                  winner = 0;
         m_ack_a = (winner == 1);
         m_ack_b = (winner == 2);
         m_en    = 0;
         if (winner != 0) begin
            m_sel       = (winner == 1);
            m_addr      = (winner == 1) ? bus.AddrA : bus.AddrB;
            m_data      = (winner == 1) ? bus.DataA : bus.DataB;
            m_en        = (m_addr != 0);
            m_next_is_a = (winner == 2);
         end
      end
      @(posedge Clk);
      #1;
      check("ack_a",   64'(bus.AckA),   64'(m_ack_a));
      check("ack_b",   64'(bus.AckB),   64'(m_ack_b));
      check("mux_sel", 64'(bus.MuxSel), 64'(m_sel));
      check("wr_en",   64'(bus.WrEn),   64'(m_en));
      check("wr_addr", 64'(bus.WrAddr), 64'(m_addr));
      check("wr_data", 64'(bus.WrData), 64'(m_data));
      check("busy",    64'(bus.Busy),
            64'((bus.ReqA && !m_ack_a) || (bus.ReqB && !m_ack_b)));
      if (bus.WrEn === 1'b1) wr_cnt++;
      if (bus.AckB === 1'b1) seen_b = 1;
      if (bus.WrEn === 1'b1 && bus.WrAddr === 5'd9) bad_addr = 1;
   endtask

   initial begin
      Rst = 1;
      bus.ReqA = 0; bus.AddrA = '0; bus.DataA = '0;
      bus.ReqB = 0; bus.AddrB = '0; bus.DataB = '0;

      // Reset overrides a pending request from A
      bus.ReqA = 1; bus.AddrA = 5'd5; bus.DataA = 32'hA5A5_0005;
      step();
      step();
      check("rst_ack_a", 64'(bus.AckA), 64'd0);
      check("rst_wr_en", 64'(bus.WrEn), 64'd0);
      Rst = 0;
      step();
      check("t1_ack_a",   64'(bus.AckA),   64'd1);
      check("t1_mux_sel", 64'(bus.MuxSel), 64'd1);
      check("t1_wr_addr", 64'(bus.WrAddr), 64'd5);
      check("t1_wr_en",   64'(bus.WrEn),   64'd1);

      // A alone held for six cycles writes every other cycle
      bus.AddrA = 5'd3; bus.DataA = 32'hDEAD_BEEF;
      wr_cnt = 0;
      for (int k = 0; k < 6; k++) step();
      check("t2_writes", 64'(wr_cnt), 64'd3);
      check("t2_data",   64'(bus.WrData), 64'hDEAD_BEEF);

      // Both held from reset alternate A,B,A,B
      Rst = 1;
      bus.ReqA = 1; bus.AddrA = 5'd1; bus.DataA = 32'h0000_00A1;
      bus.ReqB = 1; bus.AddrB = 5'd2; bus.DataB = 32'h0000_00B2;
      step();
      Rst = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         check("t3_wr_addr", 64'(bus.WrAddr), (k % 2 == 0) ? 64'd1 : 64'd2);
         check("t3_mux_sel", 64'(bus.MuxSel), (k % 2 == 0) ? 64'd1 : 64'd0);
      end

      // B writing register $0: acknowledged, not enabled
      Rst = 1;
      bus.ReqA = 0;
      bus.ReqB = 1; bus.AddrB = 5'd0; bus.DataB = 32'h0000_1234;
      step();
      Rst = 0;
      step();
      check("t4_ack_b",   64'(bus.AckB),   64'd1);
      check("t4_mux_sel", 64'(bus.MuxSel), 64'd0);
      check("t4_wr_en",   64'(bus.WrEn),   64'd0);

      // B withdrawn after one cycle while A takes the slot
      Rst = 1;
      bus.ReqA = 0; bus.ReqB = 0;
      step();
      Rst = 0;
      bus.ReqA = 1; bus.AddrA = 5'd4; bus.DataA = 32'h0000_0044;
      bus.ReqB = 1; bus.AddrB = 5'd9; bus.DataB = 32'h0000_0099;
      seen_b = 0; bad_addr = 0;
      step();
      check("t5_ack_a", 64'(bus.AckA), 64'd1);
      bus.ReqA = 0; bus.ReqB = 0;
      for (int k = 0; k < 3; k++) step();
      check("t5_no_ack_b", 64'(seen_b),   64'd0);
      check("t5_no_write", 64'(bad_addr), 64'd0);
      bus.ReqA = 1; bus.ReqB = 1;
      step();
      check("t5_ptr_b", 64'(bus.AckB), 64'd1);

      // Same address from both with pointer at B: B's data then A's data
      Rst = 1;
      bus.ReqA = 0; bus.ReqB = 0;
      step();
      Rst = 0;
      bus.ReqA = 1; bus.AddrA = 5'd7; bus.DataA = 32'h0000_0011;
      step();
      bus.ReqA = 0;
      step();
      bus.ReqA = 1; bus.ReqB = 1; bus.AddrB = 5'd7; bus.DataB = 32'h0000_0022;
      step();
      check("t6_first_data",  64'(bus.WrData), 64'h22);
      check("t6_first_addr",  64'(bus.WrAddr), 64'd7);
      step();
      check("t6_second_data", 64'(bus.WrData), 64'h11);
      check("t6_second_sel",  64'(bus.MuxSel), 64'd1);

      // Randomized traffic; Addr/Data stay stable while a request is pending
      bus.ReqA = 0; bus.ReqB = 0;
      for (int i = 0; i < 400; i++) begin
         if (bus.ReqA && !bus.AckA) begin
            if ($urandom_range(7) == 0) bus.ReqA = 0;
         end else begin
            bus.ReqA  = 1'($urandom_range(1));
            bus.AddrA = ($urandom_range(3) == 0) ? 5'd0 : AW'($urandom_range(7));
            bus.DataA = $urandom;
         end
         if (bus.ReqB && !bus.AckB) begin
            if ($urandom_range(7) == 0) bus.ReqB = 0;
         end else begin
            bus.ReqB  = 1'($urandom_range(1));
            bus.AddrB = ($urandom_range(3) == 0) ? 5'd0 : AW'($urandom_range(7));
            bus.DataB = $urandom;
         end
         Rst = ($urandom_range(63) == 0);
         step();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_wb_port_arbiter
`default_nettype wire

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters.
  - Requester A: ALU/primary path.
  - Requester B: load/secondary path.
- Arbitrates round-robin and drives the select of the 5-bit destination-register 2:1 mux (sel=1 passes input A).
- Presents a registered write address, data and enable to the register file.
- Sits between the writeback sources and the register-file write port.

Parameters:
- DATA_W, 32, write-data width.
- ADDR_W, 5, register-address width (matches the 5-bit destination mux).

Ports:
- Clk  input  1  sole clock, rising edge.
- Rst  input  1  synchronous, active-high reset.
- ReqA  input  1  requester A write request, level.
- AddrA  input  ADDR_W  requester A destination register.
- DataA  input  DATA_W  requester A write data.
- AckA  output  1  one-cycle grant acknowledge to A.
- ReqB  input  1  requester B write request, level.
- AddrB  input  ADDR_W  requester B destination register.
- DataB  input  DATA_W  requester B write data.
- AckB  output  1  one-cycle grant acknowledge to B.
- MuxSel  output  1  select to the destination-register mux (1 = A, 0 = B).
- WrEn  output  1  register-file write enable.
- WrAddr  output  ADDR_W  register-file write address.
- WrData  output  DATA_W  register-file write data.
- Busy  output  1  high when either Req is pending and not acked this cycle.

Behaviour:
- Reset: Clk and Rst only, synchronous active-high. When Rst=1 at a rising edge:
  - AckA=AckB=WrEn=0, MuxSel=1, WrAddr=0, WrData=0.
  - Priority pointer = A.
  - Rst overrides any pending request; a request present during reset is neither acked nor written.
- State: one-bit priority pointer (PRI_A / PRI_B), plus registered outputs. No other state.
- Eligibility in cycle N:
  - ReqX is eligible if ReqX=1 and AckX=0 in cycle N.
  - A request in the same cycle as its own Ack counts as already consumed.
- Grant decision in cycle N (combinational, registered at the edge ending N):
  - Only A eligible -> grant A.
  - Only B eligible -> grant B.
  - Both eligible -> grant the side the pointer names.
  - Neither eligible -> no grant.
- Registered effects in cycle N+1 when X is granted (latency = 1 cycle):
  - AckX=1; the other Ack=0.
  - MuxSel=1 for A, 0 for B.
  - WrAddr=AddrX, WrData=DataX sampled at the N edge.
  - WrEn=1, unless AddrX==0: register $0 is never written (WrEn=0), but Ack is still given.
- Pointer update: after a grant to X, the pointer moves to the other side. It does not change when there is no grant.
- No grant: AckA=AckB=WrEn=0. MuxSel, WrAddr and WrData hold their previous values (no glitching of the mux select).
- Throughput:
  - Alternating A/B contention: one write every cycle.
  - A single requester holding Req continuously: one write every 2 cycles, due to the ack-cycle exclusion.
- Requester contract:
  - Addr and Data must be stable while Req=1 until the Ack cycle.
  - A Req dropped before its Ack is simply withdrawn; no write occurs.
- Starvation: under continuous dual contention, each side waits at most 1 grant slot.
- Busy = (ReqA & ~AckA) | (ReqB & ~AckB), combinational.
- Simultaneous same address from A and B: no merging. Both writes occur in grant order, so the later grant wins in the register file.

Decomposition:
- Shared package/header holds:
  - Constants SEL_A=1'b1, SEL_B=1'b0.
  - Pointer encodings PRI_A, PRI_B.
  - Default widths DATA_W and ADDR_W.
- One natural sub-module: rr_arbiter2 (2-way round-robin grant plus pointer flop, ack-cycle masking).
- The top level holds the output registers and the $0 write suppression.

Test Plan:
- Reset with ReqA=1, AddrA=5 -> no Ack or WrEn during reset. After Rst drops, AckA=1, MuxSel=1, WrAddr=5, WrEn=1 exactly 1 cycle later.
- ReqA only, AddrA=3, DataA=0xDEADBEEF, held 6 cycles -> AckA/WrEn high in alternate cycles (3 writes), WrData=0xDEADBEEF each time.
- ReqA and ReqB both held from reset, AddrA=1, AddrB=2 -> grants A,B,A,B on consecutive cycles; MuxSel toggles 1,0,1,0; WrAddr 1,2,1,2.
- ReqB only, AddrB=0, DataB=0x1234 -> AckB=1, MuxSel=0, WrEn=0.
- ReqB=1 for one cycle while A holds the grant slot, then withdrawn -> no AckB, no write with WrAddr=AddrB, pointer unchanged by B.
- Both request AddrA=AddrB=7 with DataA=0x11, DataB=0x22, pointer at B -> write 0x22, then 0x11, to r7 on consecutive cycles.
